// File: rtl/systolic_2_feeder_pkg.sv
// systolic_2_feeder_pkg: shared defaults and FSM state encoding for the systolic_2 feeder and its bench.
package systolic_2_feeder_pkg;
    localparam int DEPTH_DEF = 8;
    localparam int W_DEF = 32;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/systolic_2_feeder_if.sv
// systolic_2_feeder_if: buffer-load, burst-control and sample-stream signals of the feeder.
interface systolic_2_feeder_if import systolic_2_feeder_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W = W_DEF
);
    localparam int AW = $clog2(DEPTH);
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0] wr_x1;
    logic [W-1:0] wr_x2;
    logic [AW:0] len;
    logic go;
    logic busy;
    logic done;
    logic err;
    logic start;
    logic [W-1:0] x01;
    logic [W-1:0] x02;
    modport master (
        output wr_en, wr_addr, wr_x1, wr_x2, len, go,
        input busy, done, err, start, x01, x02
    );
    modport slave (
        input wr_en, wr_addr, wr_x1, wr_x2, len, go,
        output busy, done, err, start, x01, x02
    );
endinterface

// File: rtl/systolic_2_feeder_buf.sv
// feeder_buf: DEPTH x 2W sample-pair array, one write port, combinational read; contents survive reset.
module feeder_buf #(
    parameter int DEPTH = 8,
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wa,
    input  logic [W-1:0]             wx1,
    input  logic [W-1:0]             wx2,
    input  logic [$clog2(DEPTH)-1:0] ra,
    output logic [W-1:0]             rx1,
    output logic [W-1:0]             rx2
);
    logic [2*W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wa] <= {wx1, wx2};
    assign {rx1, rx2} = mem[ra];
endmodule

// File: rtl/systolic_2_feeder.sv
// systolic_2_feeder: streams a stored burst of sample pairs into systolic_2 with start/busy/done framing.
module systolic_2_feeder import systolic_2_feeder_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W = W_DEF
) (
    input logic clk,
    input logic rst,
    systolic_2_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [1:0] state;
    logic [AW:0] idx;
    logic [AW:0] len_q;
    logic start_q, busy_q, done_q, err_q;
    logic [W-1:0] x1_q, x2_q;
    logic [W-1:0] rd_x1, rd_x2;
    logic [W-1:0] s0_x1, s0_x2;
    logic we, len_ok, last;
    assign we = bus.wr_en && state == IDLE;
    assign len_ok = bus.len != '0 && bus.len <= (AW+1)'(DEPTH);
    assign last = idx == len_q;
    // idx rests at 0 outside STREAM, so the array already presents entry 0 when go arrives
    feeder_buf #(.DEPTH(DEPTH), .W(W)) u_buf (
        .clk(clk), .we(we), .wa(bus.wr_addr), .wx1(bus.wr_x1), .wx2(bus.wr_x2),
        .ra(idx[AW-1:0]), .rx1(rd_x1), .rx2(rd_x2)
    );
    // a same-cycle write to entry 0 must reach the first sample of the burst
    assign s0_x1 = (we && bus.wr_addr == '0) ? bus.wr_x1 : rd_x1;
    assign s0_x2 = (we && bus.wr_addr == '0) ? bus.wr_x2 : rd_x2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx <= '0;
            len_q <= '0;
            start_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            x1_q <= '0;
            x2_q <= '0;
        end else begin
            start_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.go && len_ok) begin
                    state <= STREAM;
                    len_q <= bus.len;
                    idx <= (AW+1)'(1);
                    start_q <= 1'b1;
                    busy_q <= 1'b1;
                    x1_q <= s0_x1;
                    x2_q <= s0_x2;
                end else if (bus.go) begin
                    err_q <= 1'b1;
                end
            end else if (state == STREAM) begin
                if (last) begin
                    state <= DONE;
                    idx <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    x1_q <= '0;
                    x2_q <= '0;
                end else begin
                    idx <= idx + 1'b1;
                    x1_q <= rd_x1;
                    x2_q <= rd_x2;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
    assign bus.start = start_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err = err_q;
    assign bus.x01 = x1_q;
    assign bus.x02 = x2_q;
endmodule

// File: tb/tb_systolic_2_feeder.sv
// tb_systolic_2_feeder: directed scoreboard bench for the systolic_2 feeder.
module tb_systolic_2_feeder;
    import systolic_2_feeder_pkg::*;
    typedef struct packed {
        logic start;
        logic busy;
        logic done;
        logic err;
        logic [31:0] x1;
        logic [31:0] x2;
    } obs_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    obs_t exp_q[$];
    logic [31:0] ref1 [8];
    logic [31:0] ref2 [8];
    systolic_2_feeder_if #(.DEPTH(8), .W(32)) bus ();
    systolic_2_feeder #(.DEPTH(8), .W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {bus.start, bus.busy, bus.done, bus.err, bus.x01, bus.x02};
    endfunction

    // every cycle pops one expectation; an empty scoreboard means an idle, all-zero cycle
    task automatic tick(input string tag);
        obs_t got;
        obs_t e;
        @(posedge clk);
        #1;
        got = observe();
        e = exp_q.size() != 0 ? exp_q.pop_front() : obs_t'('0);
        n_cmp++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
    endtask

    task automatic check_zero(input string tag);
        obs_t got;
        got = observe();
        n_cmp++;
        assert (got === obs_t'('0)) else begin
            n_err++;
            $error("FAIL %s: observed %h expected 0", tag, got);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] v1, input logic [31:0] v2);
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_x1 = v1;
        bus.wr_x2 = v2;
        ref1[a] = v1;
        ref2[a] = v2;
        tick("write");
        bus.wr_en = 1'b0;
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({i == 0, 1'b1, 1'b0, 1'b0, ref1[i], ref2[i]});
        exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0});
    endtask

    task automatic burst(input int n, input string tag);
        bus.go = 1'b1;
        bus.len = 4'(n);
        push_burst(n);
        tick(tag);
        bus.go = 1'b0;
        bus.wr_en = 1'b0;
        repeat (n) tick(tag);
    endtask

    task automatic bad_go(input int n, input string tag);
        bus.go = 1'b1;
        bus.len = 4'(n);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
        tick(tag);
        bus.go = 1'b0;
        tick({tag, "_after"});
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_x1 = '0;
        bus.wr_x2 = '0;
        bus.len = '0;
        bus.go = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) wr(i, 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i));
        tick("idle");
        burst(6, "len6");
        tick("len6_tail");
        bad_go(0, "len0");
        bad_go(9, "len9");
        burst(8, "len8");
        tick("len8_tail");
        // go and writes held through a whole burst must neither restart it nor touch the array
        bus.go = 1'b1;
        bus.len = 4'd4;
        push_burst(4);
        tick("hold");
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_x1 = 32'hDEAD_BEEF;
        bus.wr_x2 = 32'hCAFE_F00D;
        repeat (5) tick("hold");
        bus.go = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 3'd2;
        tick("hold_idle");
        burst(8, "replay");
        tick("replay_tail");
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_x1 = 32'h1234_5678;
        bus.wr_x2 = 32'h8765_4321;
        ref1[0] = 32'h1234_5678;
        ref2[0] = 32'h8765_4321;
        burst(3, "wr_go");
        tick("wr_go_tail");
        // abort after sample 2 is visible (cycle k+3)
        bus.go = 1'b1;
        bus.len = 4'd6;
        push_burst(6);
        tick("abort");
        bus.go = 1'b0;
        repeat (2) tick("abort");
        #2;
        rst = 1'b0;
        #1;
        check_zero("abort_async");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick("abort_nodone");
        burst(6, "after_abort");
        bus.go = 1'b1;
        bus.len = 4'd3;
        tick("go_in_done");
        burst(3, "b2b_1");
        bus.go = 1'b1;
        tick("b2b_ignored");
        burst(2, "b2b_2");
        repeat (2) tick("final_idle");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
